// File: rtl/datapath_regbank_if.sv
// Control-word, memory and status signal bundle between the control unit
// (master) and the register-transfer datapath (slave).
interface datapath_regbank_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int IR_W   = 8
);
   logic [12:0]       write_en;
   logic [3:0]        bus_ld;
   logic [1:0]        inc;
   logic [2:0]        clr;
   logic [3:0]        alu_mode;
   logic              dm_wr;
   logic              im_wr;
   logic [DATA_W-1:0] im_rdata;
   logic [DATA_W-1:0] dm_rdata;
   logic [ADDR_W-1:0] im_addr;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              dm_we;
   logic              im_we;
   logic [IR_W-1:0]   ir;
   logic              z;
   logic [DATA_W-1:0] bus_dbg;

   modport master (
      output write_en, bus_ld, inc, clr, alu_mode, dm_wr, im_wr,
      output im_rdata, dm_rdata,
      input  im_addr, dm_addr, mem_wdata, dm_we, im_we, ir, z, bus_dbg
   );

   modport slave (
      input  write_en, bus_ld, inc, clr, alu_mode, dm_wr, im_wr,
      input  im_rdata, dm_rdata,
      output im_addr, dm_addr, mem_wdata, dm_we, im_we, ir, z, bus_dbg
   );
endinterface

// File: rtl/datapath_regbank.sv
// Register-transfer datapath: architectural registers, shared bus mux,
// accumulator ALU and memory address/data drive for the control unit.
module datapath_regbank #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int IR_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   datapath_regbank_if.slave  dp
);

   typedef enum logic [3:0] {
      SRC_IMEM = 4'd0,
      SRC_DMEM = 4'd1,
      SRC_PC   = 4'd2,
      SRC_DR   = 4'd3,
      SRC_R    = 4'd4,
      SRC_AC   = 4'd5,
      SRC_TR   = 4'd6,
      SRC_R1   = 4'd7,
      SRC_R2   = 4'd8,
      SRC_RI   = 4'd9,
      SRC_RJ   = 4'd10,
      SRC_RK   = 4'd11
   } bus_src_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_MULT = 4'd2,
      ALU_PASS = 4'd5
   } alu_mode_e;

   typedef enum logic [1:0] {
      INC_NONE = 2'b00,
      INC_PC   = 2'b01,
      INC_AC   = 2'b10,
      INC_NOP  = 2'b11
   } inc_e;

   localparam int WE_ARB = 12;
   localparam int WE_AR  = 11;
   localparam int WE_PC  = 10;
   localparam int WE_DR  = 9;
   localparam int WE_IR  = 8;
   localparam int WE_R   = 7;
   localparam int WE_TR  = 6;
   localparam int WE_AC  = 5;
   localparam int WE_R1  = 4;
   localparam int WE_R2  = 3;
   localparam int WE_RI  = 2;
   localparam int WE_RJ  = 1;
   localparam int WE_RK  = 0;

   logic [ADDR_W-1:0] arb_q, ar_q, pc_q;
   logic [DATA_W-1:0] dr_q, r_q, tr_q, ac_q, r1_q, r2_q, ri_q, rj_q, rk_q;
   logic [IR_W-1:0]   ir_q;
   logic              z_q;

   logic [DATA_W-1:0] bus_w;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] ac_next;
   logic [DATA_W-1:0] tr_next;
   logic [ADDR_W-1:0] pc_next;
   logic              ac_touch;
   inc_e              inc_sel;

   assign inc_sel = inc_e'(dp.inc);

   // Shared bus: PC is zero-extended, unused codes drive zero.
   always_comb begin
      bus_w = '0;
      case (bus_src_e'(dp.bus_ld))
         SRC_IMEM: bus_w = dp.im_rdata;
         SRC_DMEM: bus_w = dp.dm_rdata;
         SRC_PC:   bus_w = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
         SRC_DR:   bus_w = dr_q;
         SRC_R:    bus_w = r_q;
         SRC_AC:   bus_w = ac_q;
         SRC_TR:   bus_w = tr_q;
         SRC_R1:   bus_w = r1_q;
         SRC_R2:   bus_w = r2_q;
         SRC_RI:   bus_w = ri_q;
         SRC_RJ:   bus_w = rj_q;
         SRC_RK:   bus_w = rk_q;
         default:  bus_w = '0;
      endcase
   end

   always_comb begin
      alu_out = bus_w;
      case (alu_mode_e'(dp.alu_mode))
         ALU_ADD:  alu_out = ac_q + bus_w;
         ALU_SUB:  alu_out = ac_q - bus_w;
         ALU_MULT: alu_out = ac_q * bus_w;
         ALU_PASS: alu_out = bus_w;
         default:  alu_out = bus_w;
      endcase
   end

   // Registers with clr/inc sources resolve clr > inc > write_en here.
   always_comb begin
      ac_next  = ac_q;
      ac_touch = 1'b0;
      if (dp.clr[2]) begin
         ac_next  = '0;
         ac_touch = 1'b1;
      end else if (inc_sel == INC_AC) begin
         ac_next  = ac_q + 1'b1;
         ac_touch = 1'b1;
      end else if (dp.write_en[WE_AC]) begin
         ac_next  = alu_out;
         ac_touch = 1'b1;
      end

      tr_next = tr_q;
      if (dp.clr[1])
         tr_next = '0;
      else if (dp.write_en[WE_TR])
         tr_next = bus_w;

      pc_next = pc_q;
      if (dp.clr[0])
         pc_next = '0;
      else if (inc_sel == INC_PC)
         pc_next = pc_q + 1'b1;
      else if (dp.write_en[WE_PC])
         pc_next = bus_w[ADDR_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_q <= '0;
         ar_q  <= '0;
         pc_q  <= '0;
         dr_q  <= '0;
         ir_q  <= '0;
         r_q   <= '0;
         tr_q  <= '0;
         ac_q  <= '0;
         r1_q  <= '0;
         r2_q  <= '0;
         ri_q  <= '0;
         rj_q  <= '0;
         rk_q  <= '0;
         z_q   <= 1'b1;
      end else begin
         if (dp.write_en[WE_ARB]) arb_q <= bus_w[ADDR_W-1:0];
         if (dp.write_en[WE_AR])  ar_q  <= bus_w[ADDR_W-1:0];
         if (dp.write_en[WE_DR])  dr_q  <= bus_w;
         if (dp.write_en[WE_IR])  ir_q  <= bus_w[IR_W-1:0];
         if (dp.write_en[WE_R])   r_q   <= bus_w;
         if (dp.write_en[WE_R1])  r1_q  <= bus_w;
         if (dp.write_en[WE_R2])  r2_q  <= bus_w;
         if (dp.write_en[WE_RI])  ri_q  <= bus_w;
         if (dp.write_en[WE_RJ])  rj_q  <= bus_w;
         if (dp.write_en[WE_RK])  rk_q  <= bus_w;
         pc_q <= pc_next;
         tr_q <= tr_next;
         ac_q <= ac_next;
         if (ac_touch) z_q <= (ac_next == '0);
      end
   end

   assign dp.im_addr   = ar_q;
   assign dp.dm_addr   = arb_q;
   assign dp.mem_wdata = bus_w;
   assign dp.bus_dbg   = bus_w;
   assign dp.dm_we     = dp.dm_wr;
   assign dp.im_we     = dp.im_wr;
   assign dp.ir        = ir_q;
   assign dp.z         = z_q;

endmodule

// File: tb/tb_datapath_regbank.sv
// Directed bench for datapath_regbank: stimulus queues expected observations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_datapath_regbank;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int IR_W   = 8;

   localparam int SIG_BUS   = 0;
   localparam int SIG_IMA   = 1;
   localparam int SIG_DMA   = 2;
   localparam int SIG_IR    = 3;
   localparam int SIG_Z     = 4;
   localparam int SIG_WDATA = 5;
   localparam int SIG_DMWE  = 6;
   localparam int SIG_IMWE  = 7;

   typedef struct {
      int          sig;
      logic [15:0] val;
      string       name;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t q[$];
   int   total;
   int   bad;

   datapath_regbank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IR_W(IR_W)) dp_if ();

   datapath_regbank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IR_W(IR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dp    (dp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] observe(input int sig);
      case (sig)
         SIG_BUS:   return dp_if.bus_dbg;
         SIG_IMA:   return {8'h00, dp_if.im_addr};
         SIG_DMA:   return {8'h00, dp_if.dm_addr};
         SIG_IR:    return {8'h00, dp_if.ir};
         SIG_Z:     return {15'h0, dp_if.z};
         SIG_WDATA: return dp_if.mem_wdata;
         SIG_DMWE:  return {15'h0, dp_if.dm_we};
         default:   return {15'h0, dp_if.im_we};
      endcase
   endfunction

   // Monitor: every falling edge, compare all pending expectations.
   initial begin
      exp_t e;
      logic [15:0] act;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e   = q.pop_front();
            act = observe(e.sig);
            total++;
            if (act !== e.val) begin
               bad++;
               $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.val);
            end
         end
      end
   end

   task automatic expect_val(input int sig, input logic [15:0] val, input string name);
      exp_t e;
      e.sig  = sig;
      e.val  = val;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic nop();
      dp_if.write_en = '0;
      dp_if.bus_ld   = 4'd0;
      dp_if.inc      = 2'b00;
      dp_if.clr      = 3'b000;
      dp_if.alu_mode = 4'd5;
      dp_if.dm_wr    = 1'b0;
      dp_if.im_wr    = 1'b0;
      dp_if.im_rdata = '0;
      dp_if.dm_rdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int bit_idx, input logic [15:0] val);
      nop();
      dp_if.im_rdata          = val;
      dp_if.write_en[bit_idx] = 1'b1;
      tick();
   endtask

   task automatic peek(input logic [3:0] src, input logic [15:0] val, input string name);
      nop();
      dp_if.bus_ld = src;
      expect_val(SIG_BUS, val, name);
      tick();
   endtask

   initial begin
      int waited;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      nop();
      repeat (2) @(posedge clk);
      #1;
      expect_val(SIG_Z, 16'h1, "z_after_por");
      expect_val(SIG_IR, 16'h0, "ir_after_por");
      rst_n = 1'b1;
      tick();

      // Load everything with 0x55, then reset mid-cycle
      nop();
      dp_if.im_rdata = 16'h0055;
      dp_if.write_en = '1;
      tick();
      expect_val(SIG_IMA, 16'h55, "pre_rst_im_addr");
      expect_val(SIG_DMA, 16'h55, "pre_rst_dm_addr");
      expect_val(SIG_IR,  16'h55, "pre_rst_ir");
      expect_val(SIG_Z,   16'h0,  "pre_rst_z");
      peek(4'd8, 16'h0055, "pre_rst_r2");

      nop();
      dp_if.write_en = '1;
      dp_if.bus_ld   = 4'd5;
      #2;
      rst_n = 1'b0;
      expect_val(SIG_IMA, 16'h0, "rst_im_addr");
      expect_val(SIG_DMA, 16'h0, "rst_dm_addr");
      expect_val(SIG_IR,  16'h0, "rst_ir");
      expect_val(SIG_Z,   16'h1, "rst_z");
      expect_val(SIG_BUS, 16'h0, "rst_ac_on_bus");
      tick();
      expect_val(SIG_IMA, 16'h0, "rst_held_im_addr");
      nop();
      rst_n = 1'b1;
      tick();
      peek(4'd2, 16'h0000, "rst_pc");
      peek(4'd8, 16'h0000, "rst_r2");

      // Fetch sequence
      load(10, 16'h0003);
      nop();
      dp_if.bus_ld = 4'd2;
      dp_if.write_en[11] = 1'b1;
      tick();
      expect_val(SIG_IMA, 16'h3, "fetch_im_addr");
      nop();
      dp_if.im_rdata = 16'h001C;
      dp_if.write_en[9] = 1'b1;
      dp_if.inc = 2'b01;
      tick();
      nop();
      dp_if.bus_ld = 4'd3;
      dp_if.write_en[8] = 1'b1;
      tick();
      expect_val(SIG_IR, 16'h1C, "fetch_ir");
      peek(4'd2, 16'h0004, "fetch_pc");
      peek(4'd3, 16'h001C, "fetch_dr");

      // ALU modes
      load(5, 16'd7);
      load(7, 16'd5);
      nop();
      dp_if.alu_mode = 4'd2;
      dp_if.bus_ld = 4'd4;
      dp_if.write_en[5] = 1'b1;
      tick();
      peek(4'd5, 16'd35, "mult_ac");
      expect_val(SIG_Z, 16'h0, "mult_z");
      load(4, 16'd35);
      nop();
      dp_if.alu_mode = 4'd1;
      dp_if.bus_ld = 4'd7;
      dp_if.write_en[5] = 1'b1;
      tick();
      peek(4'd5, 16'd0, "sub_ac");
      expect_val(SIG_Z, 16'h1, "sub_z");
      load(6, 16'hFFFF);
      nop();
      dp_if.alu_mode = 4'd0;
      dp_if.bus_ld = 4'd6;
      dp_if.write_en[5] = 1'b1;
      tick();
      peek(4'd5, 16'hFFFF, "add_ac");
      expect_val(SIG_Z, 16'h0, "add_z");
      nop();
      dp_if.inc = 2'b10;
      tick();
      peek(4'd5, 16'h0000, "inc_ac_wrap");
      expect_val(SIG_Z, 16'h1, "inc_ac_z");

      // Priority and PC wrap
      load(5, 16'd5);
      expect_val(SIG_Z, 16'h0, "prio_pre_z");
      nop();
      dp_if.im_rdata = 16'd9;
      dp_if.write_en[5] = 1'b1;
      dp_if.clr = 3'b100;
      tick();
      peek(4'd5, 16'h0000, "clr_over_we_ac");
      expect_val(SIG_Z, 16'h1, "clr_ac_z");
      load(10, 16'd7);
      nop();
      dp_if.clr = 3'b001;
      dp_if.inc = 2'b01;
      tick();
      peek(4'd2, 16'h0000, "clr_over_inc_pc");
      load(10, 16'h00FF);
      nop();
      dp_if.inc = 2'b01;
      tick();
      peek(4'd2, 16'h0000, "pc_wrap");
      load(10, 16'h0010);
      nop();
      dp_if.im_rdata = 16'h0040;
      dp_if.write_en[10] = 1'b1;
      dp_if.inc = 2'b01;
      tick();
      peek(4'd2, 16'h0011, "inc_over_we_pc");

      // Store path
      load(12, 16'h0020);
      load(6, 16'h1234);
      nop();
      dp_if.bus_ld = 4'd6;
      dp_if.dm_wr = 1'b1;
      expect_val(SIG_DMA,   16'h20,   "store_dm_addr");
      expect_val(SIG_WDATA, 16'h1234, "store_wdata");
      expect_val(SIG_DMWE,  16'h1,    "store_dm_we");
      expect_val(SIG_IMWE,  16'h0,    "store_im_we");
      tick();
      peek(4'd6, 16'h1234, "store_tr_kept");
      expect_val(SIG_DMA, 16'h20, "store_arb_kept");
      nop();
      dp_if.im_wr = 1'b1;
      expect_val(SIG_IMWE, 16'h1, "im_we_follow");
      expect_val(SIG_DMWE, 16'h0, "dm_we_idle");
      tick();

      // Simultaneous loads read pre-edge values
      load(5, 16'd2);
      load(6, 16'd9);
      nop();
      dp_if.bus_ld = 4'd5;
      dp_if.write_en[6] = 1'b1;
      tick();
      peek(4'd6, 16'd2, "swap_tr");
      peek(4'd5, 16'd2, "swap_ac");
      nop();
      dp_if.bus_ld = 4'd12;
      expect_val(SIG_BUS, 16'h0, "bus_code12");
      tick();
      load(5, 16'd3);
      nop();
      dp_if.bus_ld = 4'd5;
      dp_if.alu_mode = 4'd0;
      dp_if.write_en[6] = 1'b1;
      dp_if.write_en[5] = 1'b1;
      tick();
      peek(4'd6, 16'd3, "dual_tr_old_ac");
      peek(4'd5, 16'd6, "dual_ac_double");
      nop();
      dp_if.bus_ld = 4'd3;
      dp_if.write_en[9] = 1'b1;
      tick();
      peek(4'd3, 16'h001C, "dr_self_hold");
      nop();
      dp_if.dm_rdata = 16'hBEEF;
      dp_if.bus_ld = 4'd1;
      dp_if.write_en[0] = 1'b1;
      tick();
      peek(4'd11, 16'hBEEF, "rk_from_dmem");
      nop();
      dp_if.alu_mode = 4'd7;
      dp_if.im_rdata = 16'h00A5;
      dp_if.write_en[5] = 1'b1;
      tick();
      peek(4'd5, 16'h00A5, "alu_undef_pass");

      waited = 0;
      while (q.size() > 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/datapath_regbank.md
Name: datapath_regbank

Overview:
- Register-transfer datapath that consumes the control unit's per-cycle control word (write_en, bus_ld, inc, clr, alu_mode, dm_wr, im_wr) and returns ir and z to it.
- Holds all architectural registers, the shared bus multiplexer, the accumulator ALU and the memory address/data drive.
- Sits directly downstream of the control unit and upstream of the instruction and data memories.

Parameters:
- DATA_W, 16, width of bus, DR, R, TR, AC, R1, R2, Ri, Rj, Rk and memory data.
- ADDR_W, 8, width of PC, AR, ARB and memory addresses.
- IR_W, 8, width of the instruction register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_en  in  13  load enables: [12] ARB, [11] AR, [10] PC, [9] DR, [8] IR, [7] R, [6] TR, [5] AC, [4] R1, [3] R2, [2] Ri, [1] Rj, [0] Rk.
- bus_ld  in  4  bus source: 0 IMEM, 1 DMEM, 2 PC, 3 DR, 4 R, 5 AC, 6 TR, 7 R1, 8 R2, 9 Ri, 10 Rj, 11 Rk; 12-15 drive 0.
- inc  in  2  00 none, 01 PC+1, 10 AC+1, 11 none.
- clr  in  3  [2] AC, [1] TR, [0] PC.
- alu_mode  in  4  0 add, 1 sub, 2 mult, 5 pass; all other codes pass.
- dm_wr  in  1  data memory write strobe.
- im_wr  in  1  instruction memory write strobe.
- im_rdata  in  DATA_W  instruction memory read data, valid combinationally for im_addr.
- dm_rdata  in  DATA_W  data memory read data, valid combinationally for dm_addr.
- im_addr  out  ADDR_W  = AR.
- dm_addr  out  ADDR_W  = ARB.
- mem_wdata  out  DATA_W  = bus (combinational).
- dm_we  out  1  = dm_wr (combinational).
- im_we  out  1  = im_wr (combinational).
- ir  out  IR_W  = IR register.
- z  out  1  zero flag register.
- bus_dbg  out  DATA_W  = bus (combinational, for probing).

Behaviour:
- Reset: all registers 0; z=1; outputs follow (im_addr=0, dm_addr=0, ir=0). Reset is asynchronous and overrides any in-flight operation; the first edge after deassertion obeys the control inputs.
- Bus: combinational mux per bus_ld. Narrow sources (PC) are zero-extended; narrow destinations (AR, ARB, PC, IR) take the low bits of the bus.
- Each register loads the bus on clk when its write_en bit is 1, except AC.
- AC loads alu_out when write_en[5]=1, computed from AC and the bus:
  - add: AC+bus
  - sub: AC-bus
  - mult: low DATA_W bits of AC*bus
  - pass: bus
  - All results are modulo 2^DATA_W with no saturation.
- Per-register priority: clr > inc > write_en. Examples:
  - clr[2] with write_en[5] gives AC=0.
  - inc=01 with write_en[10] gives PC+1.
  - inc=10 with write_en[5] gives AC+1.
- Wrap-around: PC increments to 0 from 2^ADDR_W-1; AC increments to 0 from 2^DATA_W-1.
- All loads are simultaneous and read the pre-edge values. Examples:
  - bus_ld=AC with write_en[6] and write_en[5] in add mode: TR receives the old AC, AC receives old AC+old AC.
  - write_en[9] with bus_ld=DR: DR holds its value.
- z flag: registered. On any edge where AC changes source (write_en[5], inc=10 or clr[2]), z = (new AC == 0). Otherwise z holds. z is not updated by other registers.
- Latency: one clock from control word to register update; memory strobes and addresses are combinational from current state.
- No internal FSM sequencing; state is the register set plus z. Operation is valid for any control word every cycle.
- Undefined write_en combinations are legal: every selected register loads.

Test Plan:
- Reset: drive write_en=all ones and bus_ld=5, assert rst_n=0 mid-cycle -> all registers 0, z=1, im_addr=0 immediately, before the next edge.
- Fetch sequence: PC=3, cycle 1 bus_ld=2 with write_en[11] -> im_addr=3. Cycle 2 im_rdata=0x001C, bus_ld=0, write_en[9], inc=01 -> DR=0x1C, PC=4. Cycle 3 bus_ld=3 with write_en[8] -> ir=0x1C.
- ALU modes, starting AC=7 and R=5:
  - mult (alu_mode=2, bus_ld=4, write_en[5]) -> AC=35.
  - then sub with R1=35 -> AC=0, z=1.
  - then add with TR=0xFFFF -> AC=0xFFFF, z=0.
  - then inc=10 -> AC=0, z=1.
- Priority: clr=3'b100 with write_en[5] and bus=9 -> AC=0. clr[0] with inc=01 -> PC=0. PC=0xFF with inc=01 -> PC=0x00.
- Store path: ARB=0x20, TR=0x1234, bus_ld=6, dm_wr=1 -> dm_addr=0x20, mem_wdata=0x1234, dm_we=1 in the same cycle; no register changes.
- Swap hazard: AC=2, TR=9, write_en[6] with bus_ld=5 -> TR=2 and AC unchanged at 2. Next cycle bus_ld=12 -> bus_dbg=0.
